// File: rtl/sc_et_sequencer.sv
// Stochastic-computing evaluation sequencer with early termination.
// Latches a job's operands onto the prb generator, waits one cycle for
// k_init to settle, steps the SC sequence index for the resulting run
// length while counting 1s of the SC output bit, then returns the count.
module sc_et_sequencer #(
    parameter int unsigned W = 6,
    parameter int unsigned N = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0][W-1:0] bx_in,
    output logic [N-1:0][W-1:0] bxs_q,
    input  logic [W-1:0]        k_init,
    output logic [W-1:0]        seq_idx,
    output logic                sc_en,
    input  logic                sc_bit,
    input  logic                abort,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [W:0]          res_count,
    output logic [W:0]          res_len,
    output logic                res_et
);

    localparam logic [W:0]   FULL_LEN = {1'b1, {W{1'b0}}};
    localparam logic [W:0]   LEN_ONE  = {{W{1'b0}}, 1'b1};
    localparam logic [W-1:0] SEQ_ONE  = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RUN,
        DONE
    } state_t;

    state_t               r_state;
    logic                 r_in_ready;
    logic                 r_sc_en;
    logic                 r_res_valid;
    logic [N-1:0][W-1:0]  r_bxs;
    logic [W-1:0]         r_seq;
    logic [W:0]           r_count;
    logic [W:0]           r_len_tgt;
    logic [W:0]           r_res_count;
    logic [W:0]           r_res_len;
    logic                 r_res_et;

    logic [W:0]           w_last_idx;
    logic                 w_last;
    logic [W:0]           w_count_nxt;

    // Last-cycle detection and running count including this cycle's bit
    always_comb begin
        w_last_idx  = r_len_tgt - LEN_ONE;
        w_last      = ({1'b0, r_seq} == w_last_idx);
        w_count_nxt = r_count + {{W{1'b0}}, sc_bit};
    end

    // Sequencer FSM with registered handshake and enable outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_sc_en     <= 1'b0;
            r_res_valid <= 1'b0;
            r_bxs       <= '0;
            r_seq       <= '0;
            r_count     <= '0;
            r_len_tgt   <= '0;
            r_res_count <= '0;
            r_res_len   <= '0;
            r_res_et    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_bxs      <= bx_in;
                        r_count    <= '0;
                        r_seq      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        r_count    <= '0;
                        r_seq      <= '0;
                        r_in_ready <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_len_tgt <= (k_init == '0) ? FULL_LEN : {1'b0, k_init};
                        r_sc_en   <= 1'b1;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_count    <= '0;
                        r_seq      <= '0;
                        r_sc_en    <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_count <= w_count_nxt;
                        // index also advances on the last cycle, so a full run wraps to 0
                        r_seq   <= r_seq + SEQ_ONE;
                        if (w_last) begin
                            r_res_count <= w_count_nxt;
                            r_res_len   <= r_len_tgt;
                            r_res_et    <= (r_len_tgt != FULL_LEN);
                            r_res_valid <= 1'b1;
                            r_sc_en     <= 1'b0;
                            r_state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                    r_sc_en    <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign sc_en     = r_sc_en;
    assign res_valid = r_res_valid;
    assign bxs_q     = r_bxs;
    assign seq_idx   = r_seq;
    assign res_count = r_res_count;
    assign res_len   = r_res_len;
    assign res_et    = r_res_et;

endmodule

// File: tb/tb_sc_et_sequencer.sv
// Scoreboard testbench for sc_et_sequencer: a driver issues jobs and
// pushes expected results, a monitor compares whatever the DUT presents.
module tb_sc_et_sequencer;

    localparam int W = 6;
    localparam int N = 2;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [N-1:0][W-1:0] bx_in;
    logic [N-1:0][W-1:0] bxs_q;
    logic [W-1:0]        k_init;
    logic [W-1:0]        seq_idx;
    logic                sc_en;
    logic                sc_bit;
    logic                abort;
    logic                res_valid;
    logic                res_ready;
    logic [W:0]          res_count;
    logic [W:0]          res_len;
    logic                res_et;

    logic [63:0]         r_pat;
    bit                  hold_ready;
    int                  checks;
    int                  failures;
    int                  cyc;

    typedef struct {
        int cnt;
        int len;
        int et;
        int t_acc;
    } exp_t;

    exp_t q[$];

    sc_et_sequencer #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bx_in     (bx_in),
        .bxs_q     (bxs_q),
        .k_init    (k_init),
        .seq_idx   (seq_idx),
        .sc_en     (sc_en),
        .sc_bit    (sc_bit),
        .abort     (abort),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_count (res_count),
        .res_len   (res_len),
        .res_et    (res_et)
    );

    // SC datapath stand-in: the output bit is a per-job pattern indexed by seq_idx
    assign sc_bit = r_pat[seq_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // k_init is only meaningful in SETTLE; scramble it while running
    always @(negedge clk) if (rst_n && sc_en) k_init = W'($urandom);

    // Consumer: random backpressure unless held off
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            res_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: run-length/index tracking, latency, and result comparison
    int  run_idx;
    bit  prev_valid;
    initial begin
        run_idx    = 0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (in_ready) begin
                    chk("idle_sc_en", sc_en, 0);
                    run_idx = 0;
                end
                if (sc_en) begin
                    chk("seq_idx_step", seq_idx, run_idx % 64);
                    run_idx++;
                end
                if (res_valid && !prev_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        chk("latency", cyc - q[0].t_acc, 1 + q[0].len);
                        chk("run_cycles", run_idx, q[0].len);
                        chk("seq_idx_done", seq_idx, q[0].len % 64);
                    end
                end
                if (res_valid && res_ready && q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("res_count", res_count, e.cnt);
                    chk("res_len", res_len, e.len);
                    chk("res_et", res_et, e.et);
                end
                prev_valid = res_valid;
            end
        end
    end

    // Reference model: expected result from the run-length rule and bit pattern
    function automatic exp_t model(input int k, input logic [63:0] pat);
        exp_t e;
        e.len = (k == 0) ? 64 : k;
        e.cnt = 0;
        for (int i = 0; i < e.len; i++) e.cnt += int'(pat[i]);
        e.et    = (e.len < 64) ? 1 : 0;
        e.t_acc = 0;
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] b1, input logic [W-1:0] b0,
                         input logic [W-1:0] k, input logic [63:0] pat, input bit push);
        int n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 300);
        if (!in_ready) begin
            chk("timeout_in_ready", 0, 1);
        end else begin
            bx_in[1] = b1;
            bx_in[0] = b0;
            k_init   = k;
            r_pat    = pat;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (push) begin
                e = model(int'(k), pat);
                e.t_acc = cyc;
                q.push_back(e);
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || !in_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    task automatic wait_run_idx(input int idx);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sc_en && seq_idx == W'(idx)) && n < 100);
        chk("reach_run_idx", (sc_en && seq_idx == W'(idx)) ? 1 : 0, 1);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        cyc        = 0;
        hold_ready = 1'b0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        abort      = 1'b0;
        bx_in      = '0;
        k_init     = '0;
        r_pat      = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_sc_en", sc_en, 0);
        chk("rst_seq_idx", seq_idx, 0);
        chk("rst_bxs_q", bxs_q, 0);
        chk("rst_res_count", res_count, 0);
        chk("rst_res_len", res_len, 0);
        chk("rst_res_et", res_et, 0);
        rst_n = 1'b1;

        // 1: k=16, ones on even indices
        issue(6'b001100, 6'b011000, 6'd16, 64'h5555_5555_5555_5555, 1);
        chk("bxs_q_latch", bxs_q, {6'b001100, 6'b011000});
        wait_idle();
        // 2: full-length run, all ones
        issue(6'd5, 6'd9, 6'd0, '1, 1);
        wait_idle();
        // 3: single-cycle run
        issue(6'd1, 6'd2, 6'd1, '1, 1);
        wait_idle();

        // 4: stall in DONE while a new job and abort are presented
        hold_ready = 1'b1;
        issue(6'd7, 6'd8, 6'd3, 64'h5, 1);
        begin
            int n;
            n = 0;
            while (!res_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        chk("stall_reached_done", res_valid, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            abort     = 1'b1;
            bx_in[1]  = 6'd33;
            bx_in[0]  = 6'd44;
            @(negedge clk);
            chk("stall_valid", res_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_bxs_q", bxs_q, {6'd7, 6'd8});
            chk("stall_count", res_count, 2);
            chk("stall_len", res_len, 3);
        end
        in_valid   = 1'b0;
        abort      = 1'b0;
        hold_ready = 1'b0;
        wait_idle();
        issue(6'd33, 6'd44, 6'd12, 64'hFFF0, 1);
        chk("post_stall_bxs_q", bxs_q, {6'd33, 6'd44});
        wait_idle();

        // 5: abort on the third RUN cycle of a k=20 job
        issue(6'd3, 6'd4, 6'd20, '1, 0);
        wait_run_idx(2);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_sc_en", sc_en, 0);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_seq_idx", seq_idx, 0);
        chk("abort_bxs_q", bxs_q, {6'd3, 6'd4});
        repeat (3) @(negedge clk);
        chk("abort_no_result", res_valid, 0);
        issue(6'd3, 6'd4, 6'd20, 64'hA5A5A, 1);
        wait_idle();

        // 6: asynchronous reset mid-run
        issue(6'd10, 6'd11, 6'd30, '1, 0);
        wait_run_idx(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_res_valid", res_valid, 0);
        chk("arst_sc_en", sc_en, 0);
        chk("arst_seq_idx", seq_idx, 0);
        chk("arst_bxs_q", bxs_q, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(6'd10, 6'd11, 6'd9, 64'h1FF, 1);
        wait_idle();

        // Randomized jobs, occasionally back-to-back
        for (int j = 0; j < 40; j++) begin
            issue(W'($urandom), W'($urandom), W'($urandom_range(0, 63)),
                  {$urandom, $urandom}, 1);
            if ($urandom_range(0, 2) == 0) wait_idle();
        end
        wait_idle();
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
